// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers with per-channel enable, glitch-free divisor reload
// and a one-cycle period tick. Optional macro MULTI_CLOCK_DIVIDER_SYNC_EN adds a global phase-align strobe.

module mcd_channel #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 250
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             ld_i,
  input  logic [DIV_W-1:0] ld_div_i,
  output logic             clk_o,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, sh_q, sh_d;
  logic             pend_q, pend_d, run_q, run_d, clk_q, clk_d, tick_q, tick_d;
  logic [DIV_W-1:0] d_eff, nxt_div, cnt_inc;
  logic [DIV_W:0]   half;
  logic             bound, restart;

  always_comb begin
    d_eff   = (act_q < DIV_W'(2)) ? DIV_W'(2) : act_q;
    half    = ({1'b0, d_eff} + (DIV_W+1)'(1)) >> 1;
    cnt_inc = cnt_q + DIV_W'(1);
    bound   = run_q && (cnt_q == d_eff - DIV_W'(1));
    restart = en_i && (!run_q || bound || sync_i);
    // a same-cycle load takes precedence over an older pending value
    nxt_div = ld_i ? ld_div_i : (pend_q ? sh_q : act_q);

    cnt_d  = cnt_q;
    act_d  = act_q;
    sh_d   = ld_i ? ld_div_i : sh_q;
    pend_d = pend_q;
    run_d  = run_q;
    clk_d  = clk_q;
    tick_d = 1'b0;

    if (!en_i) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      run_d  = 1'b0;
      act_d  = nxt_div;
      pend_d = 1'b0;
    end else if (restart) begin
      cnt_d  = '0;
      clk_d  = 1'b1;
      tick_d = 1'b1;
      run_d  = 1'b1;
      act_d  = nxt_div;
      pend_d = 1'b0;
    end else begin
      cnt_d = cnt_inc;
      clk_d = ({1'b0, cnt_inc} < half);
      if (ld_i) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      act_q  <= DIV_W'(DEFAULT_DIV);
      sh_q   <= DIV_W'(DEFAULT_DIV);
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
endmodule

module multi_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 250,
  parameter int CH_W        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              load_valid,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DIV_W-1:0]  load_div,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  input  logic              sync,
`endif
  output logic              load_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic sync_w, load_hit, load_err_q, load_err_d;

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  assign load_hit   = load_valid && ({1'b0, load_ch} < NUM_CH_L);
  assign load_err_d = load_valid && !({1'b0, load_ch} < NUM_CH_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) load_err_q <= 1'b0;
    else        load_err_q <= load_err_d;
  end
  assign load_err = load_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mcd_channel #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en[i]),
      .sync_i   (sync_w),
      .ld_i     (load_hit && (load_ch == CH_W'(i))),
      .ld_div_i (load_div),
      .clk_o    (clk_out[i]),
      .tick_o   (tick[i])
    );
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: expected per-cycle tick/clk_out patterns are queued
// from the divisor arithmetic and popped against the DUT each cycle.
module tb_multi_clock_divider;
  localparam int NCH = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           load_valid = 1'b0;
  logic [1:0]     load_ch = '0;
  logic [15:0]    load_div = '0;
  logic           load_err;
  logic [NCH-1:0] clk_out, tick;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  logic           sync = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct { logic t; logic c; } exp_t;
  exp_t sb[$];

  multi_clock_divider #(.NUM_CH(NCH), .DIV_W(16), .DEFAULT_DIV(250), .CH_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_div   (load_div),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    .sync       (sync),
`endif
    .load_err   (load_err),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // queue ncyc cycles of a free-running period of effective length d, starting at a tick
  task automatic push(input int d, input int ncyc);
    exp_t e;
    for (int k = 0; k < ncyc; k++) begin
      e.t = ((k % d) == 0);
      e.c = ((k % d) < (d + 1) / 2);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int ch, input int inj_at, input int lch, input int ldiv);
    exp_t e;
    int   k = 0;
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      chk($sformatf("tick[%0d] k=%0d", ch, k), tick[ch], e.t);
      chk($sformatf("clk_out[%0d] k=%0d", ch, k), clk_out[ch], e.c);
      chk($sformatf("load_err k=%0d", k), load_err,
          (inj_at >= 0 && k == inj_at + 1 && lch >= NCH));
      if (k == inj_at) begin
        load_valid = 1'b1; load_ch = lch[1:0]; load_div = ldiv[15:0];
      end else if (k == inj_at + 1) begin
        load_valid = 1'b0;
      end
      k++;
    end
  endtask

  task automatic do_load(input int lch, input int ldiv);
    load_valid = 1'b1; load_ch = lch[1:0]; load_div = ldiv[15:0];
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) step();
    chk("reset clk_out", clk_out, 0);
    chk("reset tick", tick, 0);
    chk("reset load_err", load_err, 0);

    // default divisor on ch0, two full periods
    reset = 1'b1;
    en = 3'b001;
    push(250, 500);
    drain(0, -1, 0, 0);

    // ch1 loaded with 3 while disabled, then enabled
    en = 3'b000;
    step();
    do_load(1, 3);
    en = 3'b010;
    push(3, 12);
    drain(1, -1, 0, 0);

    // ch0 at 10, reload 4 mid-period; then reload 5 exactly on a boundary
    en = 3'b000;
    step();
    do_load(0, 10);
    en = 3'b001;
    push(10, 10);
    push(4, 8);
    drain(0, 3, 0, 4);
    push(4, 4);
    push(5, 10);
    drain(0, 3, 0, 5);

    // divisors 0 and 1 run as 2; invalid channel flags load_err without effect
    en = 3'b000;
    step();
    do_load(0, 0);
    en = 3'b001;
    push(2, 6);
    drain(0, -1, 0, 0);
    en = 3'b000;
    step();
    do_load(0, 1);
    en = 3'b001;
    push(2, 10);
    drain(0, 2, 3, 7);

    // ch2 dropped mid high phase
    en = 3'b100;
    push(250, 50);
    drain(2, -1, 0, 0);
    en = 3'b000;
    step();
    chk("disable clk_out[2]", clk_out[2], 0);
    chk("disable tick[2]", tick[2], 0);

    // async reset mid-period with a load in flight
    en = 3'b011;
    repeat (3) step();
    load_valid = 1'b1; load_ch = 2'd0; load_div = 16'd5;
    step();
    load_valid = 1'b0;
    step();
    #1;
    reset = 1'b0;
    #1;
    chk("async reset clk_out", clk_out, 0);
    chk("async reset tick", tick, 0);
    chk("async reset load_err", load_err, 0);
    step();
    chk("held reset clk_out", clk_out, 0);
    reset = 1'b1;
    en = 3'b001;
    push(250, 250);
    drain(0, -1, 0, 0);

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    en = 3'b000;
    step();
    do_load(0, 6);
    do_load(1, 9);
    en = 3'b001;
    repeat (2) step();
    en = 3'b011;
    repeat (3) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync tick", tick[1:0], 2'b11);
    chk("sync clk_out", clk_out[1:0], 2'b11);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("post-sync tick0 k=%0d", k), tick[0], (k == 6));
      chk($sformatf("post-sync tick1 k=%0d", k), tick[1], (k == 9));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
